// File: rtl/guess_game_core.sv
// guess_game_core: N-channel reaction-game engine.
// A single lit LED (y) steps around N positions at a level-dependent rate; the
// player presses the button paired with the lit LED. Consecutive hits advance
// the level, misses cost lives, and WIN/LOSE are sticky until reset.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   lvl_sel   : starting level, sampled while rst=1
//   btn       : debounced button levels, bit i pairs with y[i]
//   y         : one-hot LED during play, all-ones on WIN, all-zeros on LOSE
//   win, lose : one-cycle pulses on entering WIN / LOSE
//   level     : current level 0..3
//   lives     : remaining lives
//   hits      : current hit streak
//   busy      : 1 while playing (RELEASE/RUN)
module guess_game_core #(
    parameter int unsigned N           = 4,
    parameter int unsigned BASE_PERIOD = 67108864,
    parameter int unsigned WIN_STREAK  = 3,
    parameter int unsigned LIVES       = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       lvl_sel,
    input  logic [N-1:0]                     btn,
    output logic [N-1:0]                     y,
    output logic                             win,
    output logic                             lose,
    output logic [1:0]                       level,
    output logic [$clog2(LIVES+1)-1:0]       lives,
    output logic [$clog2(WIN_STREAK+1)-1:0]  hits,
    output logic                             busy
);

    localparam int unsigned LW = $clog2(LIVES + 1);
    localparam int unsigned HW = $clog2(WIN_STREAK + 1);
    localparam int unsigned PW = $clog2(BASE_PERIOD);

    typedef enum logic [1:0] {
        S_RELEASE = 2'd0,
        S_RUN     = 2'd1,
        S_WIN     = 2'd2,
        S_LOSE    = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [PW-1:0] presc, presc_d;
    logic [N-1:0]  btn_q;
    logic [N-1:0]  y_d;
    logic          win_d, lose_d, busy_d;
    logic [1:0]    level_d;
    logic [LW-1:0] lives_d;
    logic [HW-1:0] hits_d;

    // Press evaluation terms
    logic [N-1:0]  pressed;
    logic          press_any, hit, streak_done, last_life;
    logic [PW-1:0] period_m1;

    assign pressed     = btn & ~btn_q;
    assign press_any   = |pressed;
    assign hit         = (pressed == y);
    assign streak_done = ((32'(hits) + 32'd1) >= WIN_STREAK);
    assign last_life   = (lives == LW'(1));
    assign period_m1   = PW'((BASE_PERIOD >> level) - 32'd1);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RELEASE;
            presc <= '0;
            btn_q <= btn;
            y     <= N'(1);
            win   <= 1'b0;
            lose  <= 1'b0;
            level <= lvl_sel;
            lives <= LW'(LIVES);
            hits  <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_d;
            presc <= presc_d;
            btn_q <= btn;
            y     <= y_d;
            win   <= win_d;
            lose  <= lose_d;
            level <= level_d;
            lives <= lives_d;
            hits  <= hits_d;
            busy  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_RELEASE: if (btn == '0) state_d = S_RUN;
            S_RUN: begin
                if (press_any) begin
                    if (hit && streak_done && (level == 2'd3))
                        state_d = S_WIN;
                    else if (!hit && last_life)
                        state_d = S_LOSE;
                    else
                        state_d = S_RELEASE;
                end
            end
            default: state_d = state;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        presc_d = presc;
        y_d     = y;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        level_d = level;
        lives_d = lives;
        hits_d  = hits;
        busy_d  = (state_d == S_RELEASE) || (state_d == S_RUN);

        if (state == S_RUN) begin
            if (press_any) begin
                // Press wins over a coincident step: no rotation this cycle
                presc_d = '0;
                if (hit) begin
                    if (!streak_done) begin
                        hits_d = hits + HW'(1);
                    end else begin
                        hits_d = '0;
                        if (level != 2'd3) level_d = level + 2'd1;
                    end
                end else begin
                    hits_d  = '0;
                    lives_d = lives - LW'(1);
                end
            end else if (presc == period_m1) begin
                presc_d = '0;
                y_d     = {y[N-2:0], y[N-1]};
            end else begin
                presc_d = presc + PW'(1);
            end
        end

        if ((state_d == S_WIN) && (state != S_WIN)) begin
            y_d   = '1;
            win_d = 1'b1;
        end
        if ((state_d == S_LOSE) && (state != S_LOSE)) begin
            y_d    = '0;
            lose_d = 1'b1;
        end
    end

endmodule
